// File: rtl/ahb_lite_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_master_if
//  Brief    : Command/response port and AHB-Lite bus bundle for the
//             ahb_lite_master initiator.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_lite_master_if #(
  parameter int ADDR_W = 4
);
  // Command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_size;
  logic [15:0]       cmd_wdata;

  // Response port
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;

  // AHB-Lite bus
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic              hsize;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [15:0]       hwdata;
  logic [15:0]       hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output hsel, haddr, hsize, htrans, hwrite, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  hsel, haddr, hsize, htrans, hwrite, hwdata,
    output hrdata, hready, hresp
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_master
//  Brief    : AHB-Lite initiator. Buffers single read/write commands in a
//             small FIFO and issues them as pipelined NONSEQ transfers
//             (address phase A overlapping data phase D), returning one
//             in-order response per transfer. Handles wait states and the
//             two-cycle ERROR response.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_master #(
  parameter int ADDR_W    = 4,
  parameter int CMD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  ahb_lite_master_if.master bus
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // One queued command
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic              size;
    logic [15:0]       wdata;
  } cmd_t;

  // Address-phase stage status. SUSPEND holds a valid command whose
  // address phase was withdrawn during the first ERROR cycle.
  typedef enum logic [1:0] {
    A_EMPTY   = 2'd0,
    A_ISSUE   = 2'd1,
    A_SUSPEND = 2'd2
  } a_state_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t              fifo_mem_q [CMD_DEPTH];
  cmd_t              fifo_mem_d [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  cmd_t              fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  // ------------------------------------------------------ A stage / bus
  a_state_t          a_state_q, a_state_d;
  logic [15:0]       a_wdata_q, a_wdata_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hsel_q, hsel_d;

  // ------------------------------------------------------------ D stage
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic              d_size_q, d_size_d;
  logic              d_lane_q, d_lane_d;
  logic [15:0]       hwdata_q, hwdata_d;

  // ----------------------------------------------------------- response
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;

  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(CMD_DEPTH));

  // Pipeline, FIFO and response next-state logic
  always_comb begin
    // Hold everything unless an event below says otherwise
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    a_state_d   = a_state_q;
    a_wdata_d   = a_wdata_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    htrans_d    = htrans_q;
    hsel_d      = hsel_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_size_d    = d_size_q;
    d_lane_d    = d_lane_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 16'h0000;
    pop         = 1'b0;

    // Push depends only on fullness, never on a same-cycle pop
    push = bus.cmd_valid && !fifo_full;

    // Data-phase completion produces the response one cycle later
    if (bus.hready && d_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = bus.hresp;
      if (d_write_q) begin
        rsp_rdata_d = 16'h0000;
      end else if (d_size_q) begin
        rsp_rdata_d = bus.hrdata;
      end else begin
        rsp_rdata_d = {8'h00, d_lane_q ? bus.hrdata[15:8] : bus.hrdata[7:0]};
      end
    end

    if (bus.hready) begin
      if (a_state_q == A_SUSPEND) begin
        // Second ERROR cycle: the withdrawn address was never sampled,
        // so D empties and A re-enters the address phase unchanged.
        d_valid_d = 1'b0;
        a_state_d = A_ISSUE;
        htrans_d  = HTRANS_NONSEQ;
        hsel_d    = 1'b1;
      end else begin
        // Normal advance: D <= A, A <= FIFO head
        d_valid_d = (a_state_q == A_ISSUE);
        d_write_d = hwrite_q;
        d_size_d  = hsize_q;
        d_lane_d  = haddr_q[0];
        if (a_state_q == A_ISSUE) begin
          hwdata_d = hsize_q ? a_wdata_q : {a_wdata_q[7:0], a_wdata_q[7:0]};
        end
        if (!fifo_empty) begin
          pop       = 1'b1;
          a_state_d = A_ISSUE;
          haddr_d   = fifo_head.addr;
          hsize_d   = fifo_head.size;
          hwrite_d  = fifo_head.write;
          a_wdata_d = fifo_head.wdata;
          htrans_d  = HTRANS_NONSEQ;
          hsel_d    = 1'b1;
        end else begin
          a_state_d = A_EMPTY;
          htrans_d  = HTRANS_IDLE;
          hsel_d    = 1'b0;
        end
      end
    end else if (bus.hresp && (a_state_q == A_ISSUE)) begin
      // First ERROR cycle: withdraw the pending address phase but keep
      // its fields so it can be reissued after the error completes.
      a_state_d = A_SUSPEND;
      htrans_d  = HTRANS_IDLE;
      hsel_d    = 1'b0;
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = '{write: bus.cmd_write, addr: bus.cmd_addr,
                               size: bus.cmd_size, wdata: bus.cmd_wdata};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers; reset drops every queued and in-flight command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      a_state_q   <= A_EMPTY;
      a_wdata_q   <= '0;
      haddr_q     <= '0;
      hsize_q     <= 1'b0;
      hwrite_q    <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hsel_q      <= 1'b0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_size_q    <= 1'b0;
      d_lane_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      a_state_q   <= a_state_d;
      a_wdata_q   <= a_wdata_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      htrans_q    <= htrans_d;
      hsel_q      <= hsel_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_size_q    <= d_size_d;
      d_lane_q    <= d_lane_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.hsel      = hsel_q;
  assign bus.haddr     = haddr_q;
  assign bus.hsize     = hsize_q;
  assign bus.htrans    = htrans_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hwdata    = hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_master
//  Brief    : Directed self-checking bench for ahb_lite_master with a small
//             byte-addressed AHB-Lite slave model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_master;

  localparam int ADDR_W    = 4;
  localparam int CMD_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_hready = 1'b1;
  logic tb_hresp  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahb_lite_master_if #(.ADDR_W(ADDR_W)) bus ();

  ahb_lite_master #(.ADDR_W(ADDR_W), .CMD_DEPTH(CMD_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Slave model: 16-byte memory, little-endian halfwords
  bit   [7:0] mem [16];
  logic       dp_valid = 1'b0;
  logic [3:0] dp_addr  = '0;
  logic       dp_write = 1'b0;
  logic       dp_size  = 1'b0;

  assign bus.hready = tb_hready;
  assign bus.hresp  = tb_hresp;
  assign bus.hrdata = {mem[{dp_addr[3:1], 1'b1}], mem[{dp_addr[3:1], 1'b0}]};

  // Slave address capture and write completion
  always @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
    end else if (tb_hready) begin
      if (dp_valid && dp_write && !tb_hresp) begin
        if (dp_size) begin
          mem[{dp_addr[3:1], 1'b0}] <= bus.hwdata[7:0];
          mem[{dp_addr[3:1], 1'b1}] <= bus.hwdata[15:8];
        end else begin
          mem[dp_addr] <= dp_addr[0] ? bus.hwdata[15:8] : bus.hwdata[7:0];
        end
      end
      dp_valid <= bus.hsel && (bus.htrans == 2'b10);
      dp_addr  <= bus.haddr;
      dp_write <= bus.hwrite;
      dp_size  <= bus.hsize;
    end
  end

  // Response log
  logic [15:0] rsp_data_log [64];
  logic        rsp_err_log  [64];
  int          rsp_cnt = 0;
  int          rd_idx  = 0;

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1 && rsp_cnt < 64) begin
      rsp_data_log[rsp_cnt] <= bus.rsp_rdata;
      rsp_err_log[rsp_cnt]  <= bus.rsp_err;
      rsp_cnt               <= rsp_cnt + 1;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [3:0] addr, input logic sz, input logic [15:0] wd);
    bit ok;
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = sz;
    bus.cmd_wdata = wd;
    do begin
      ok = bus.cmd_ready;
      tick();
      guard++;
    end while (!ok && guard < 50);
    bus.cmd_valid = 1'b0;
    if (!ok) check_value("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic expect_rsp(input string tag, input logic [15:0] rdata, input logic err);
    int waited;
    waited = 0;
    while (rsp_cnt <= rd_idx && waited < 20) begin
      tick();
      waited++;
    end
    check_value({tag, "_seen"}, 32'(rsp_cnt > rd_idx), 32'd1);
    if (rsp_cnt > rd_idx) begin
      check_value({tag, "_rdata"}, 32'(rsp_data_log[rd_idx]), 32'(rdata));
      check_value({tag, "_err"}, 32'(rsp_err_log[rd_idx]), 32'(err));
      rd_idx++;
    end
  endtask

  logic        t3_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0]  t3_addr [4] = '{4'h6, 4'h8, 4'h6, 4'h8};
  logic [15:0] t3_wd   [4] = '{16'h0001, 16'h0002, 16'h0000, 16'h0000};

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int snap;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = 1'b0;
    bus.cmd_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_value("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_value("rst_htrans",    32'(bus.htrans),    32'd0);
    check_value("rst_hsel",      32'(bus.hsel),      32'd0);
    check_value("rst_hwrite",    32'(bus.hwrite),    32'd0);
    check_value("rst_hsize",     32'(bus.hsize),     32'd0);
    check_value("rst_haddr",     32'(bus.haddr),     32'd0);
    check_value("rst_hwdata",    32'(bus.hwdata),    32'd0);
    check_value("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check_value("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);

    // Test 1: single halfword write, latency
    push(1'b1, 4'h4, 1'b1, 16'hBEEF);
    check_value("t1_e0_htrans", 32'(bus.htrans), 32'd0);
    tick();
    check_value("t1_e1_htrans", 32'(bus.htrans), 32'h2);
    check_value("t1_e1_hsel",   32'(bus.hsel),   32'd1);
    check_value("t1_e1_haddr",  32'(bus.haddr),  32'h4);
    check_value("t1_e1_hwrite", 32'(bus.hwrite), 32'd1);
    check_value("t1_e1_hsize",  32'(bus.hsize),  32'd1);
    tick();
    check_value("t1_e2_hwdata", 32'(bus.hwdata), 32'hBEEF);
    check_value("t1_e2_htrans", 32'(bus.htrans), 32'd0);
    check_value("t1_e2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_value("t1_e3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_value("t1_e3_rsp_err",   32'(bus.rsp_err),   32'd0);
    expect_rsp("t1_w4", 16'h0000, 1'b0);

    // Test 2: halfword and byte reads
    push(1'b1, 4'h2, 1'b1, 16'h1234);
    push(1'b1, 4'h4, 1'b1, 16'hAB3C);
    push(1'b1, 4'hE, 1'b1, 16'hC0DE);
    push(1'b0, 4'h2, 1'b1, 16'h0000);
    push(1'b0, 4'h5, 1'b0, 16'h0000);
    push(1'b0, 4'h4, 1'b0, 16'h0000);
    expect_rsp("t2_w2", 16'h0000, 1'b0);
    expect_rsp("t2_w4", 16'h0000, 1'b0);
    expect_rsp("t2_wE", 16'h0000, 1'b0);
    expect_rsp("t2_r2", 16'h1234, 1'b0);
    expect_rsp("t2_rb5", 16'h00AB, 1'b0);
    expect_rsp("t2_rb4", 16'h003C, 1'b0);

    // Test 3: four back-to-back commands
    for (int i = 0; i < 4; i++) begin
      push(t3_wr[i], t3_addr[i], 1'b1, t3_wd[i]);
      if (i > 0) begin
        check_value("t3_htrans", 32'(bus.htrans), 32'h2);
        check_value("t3_haddr",  32'(bus.haddr),  32'(t3_addr[i-1]));
        check_value("t3_hwrite", 32'(bus.hwrite), 32'(t3_wr[i-1]));
      end
    end
    tick();
    check_value("t3_last_htrans", 32'(bus.htrans), 32'h2);
    check_value("t3_last_haddr",  32'(bus.haddr),  32'h8);
    check_value("t3_last_hwrite", 32'(bus.hwrite), 32'd0);
    tick();
    check_value("t3_idle_htrans", 32'(bus.htrans), 32'd0);
    expect_rsp("t3_w6", 16'h0000, 1'b0);
    expect_rsp("t3_w8", 16'h0000, 1'b0);
    expect_rsp("t3_r6", 16'h0001, 1'b0);
    expect_rsp("t3_r8", 16'h0002, 1'b0);

    // Test 4: three wait states during the W 0xA data phase
    push(1'b1, 4'hA, 1'b1, 16'h5A5A);
    push(1'b0, 4'hA, 1'b1, 16'h0000);
    tick();
    check_value("t4_pre_htrans", 32'(bus.htrans), 32'h2);
    check_value("t4_pre_haddr",  32'(bus.haddr),  32'hA);
    check_value("t4_pre_hwrite", 32'(bus.hwrite), 32'd0);
    check_value("t4_pre_hwdata", 32'(bus.hwdata), 32'h5A5A);
    tb_hready = 1'b0;
    push(1'b1, 4'h9, 1'b0, 16'h0077);
    check_value("t4_s1_htrans", 32'(bus.htrans), 32'h2);
    check_value("t4_s1_haddr",  32'(bus.haddr),  32'hA);
    check_value("t4_s1_hwdata", 32'(bus.hwdata), 32'h5A5A);
    check_value("t4_s1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    push(1'b0, 4'h8, 1'b1, 16'h0000);
    check_value("t4_s2_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_value("t4_s2_htrans", 32'(bus.htrans), 32'h2);
    check_value("t4_s2_hwdata", 32'(bus.hwdata), 32'h5A5A);
    tick();
    check_value("t4_s3_haddr",  32'(bus.haddr),  32'hA);
    check_value("t4_s3_hwdata", 32'(bus.hwdata), 32'h5A5A);
    check_value("t4_s3_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("t4_s3_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tb_hready = 1'b1;
    tick();
    check_value("t4_go_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_value("t4_go_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_value("t4_go_haddr", 32'(bus.haddr), 32'h9);
    tick();
    check_value("t4_byte_hwdata", 32'(bus.hwdata), 32'h7777);
    expect_rsp("t4_wA", 16'h0000, 1'b0);
    expect_rsp("t4_rA", 16'h5A5A, 1'b0);
    expect_rsp("t4_wb9", 16'h0000, 1'b0);
    expect_rsp("t4_r8", 16'h7702, 1'b0);

    // Test 5: two-cycle ERROR on write 0x0, read 0xE reissued
    push(1'b1, 4'h0, 1'b1, 16'h1111);
    push(1'b0, 4'hE, 1'b1, 16'h0000);
    tick();
    check_value("t5_pre_htrans", 32'(bus.htrans), 32'h2);
    check_value("t5_pre_haddr",  32'(bus.haddr),  32'hE);
    tb_hresp  = 1'b1;
    tb_hready = 1'b0;
    tick();
    check_value("t5_e1_htrans", 32'(bus.htrans), 32'd0);
    check_value("t5_e1_hsel",   32'(bus.hsel),   32'd0);
    check_value("t5_e1_haddr",  32'(bus.haddr),  32'hE);
    check_value("t5_e1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tb_hready = 1'b1;
    tick();
    check_value("t5_e2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_value("t5_e2_rsp_err",   32'(bus.rsp_err),   32'd1);
    check_value("t5_e2_htrans", 32'(bus.htrans), 32'h2);
    check_value("t5_e2_hsel",   32'(bus.hsel),   32'd1);
    tb_hresp = 1'b0;
    tick();
    check_value("t5_e3_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("t5_e3_htrans", 32'(bus.htrans), 32'd0);
    expect_rsp("t5_w0", 16'h0000, 1'b1);
    expect_rsp("t5_rE", 16'hC0DE, 1'b0);

    // Single-cycle ERROR on a read: next transfer is not suspended
    push(1'b0, 4'h2, 1'b1, 16'h0000);
    push(1'b0, 4'h4, 1'b1, 16'h0000);
    tick();
    tb_hresp = 1'b1;
    tick();
    tb_hresp = 1'b0;
    check_value("t5b_rsp_err", 32'(bus.rsp_err), 32'd1);
    tick();
    check_value("t5b_next_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    expect_rsp("t5b_r2", 16'h1234, 1'b1);
    expect_rsp("t5b_r4", 16'hAB3C, 1'b0);

    // Test 6: reset with two queued and two in flight
    push(1'b1, 4'h2, 1'b1, 16'hDEAD);
    push(1'b1, 4'h4, 1'b1, 16'hDEAD);
    push(1'b1, 4'h6, 1'b1, 16'hDEAD);
    tb_hready = 1'b0;
    push(1'b1, 4'h8, 1'b1, 16'hDEAD);
    check_value("t6_full", 32'(bus.cmd_ready), 32'd0);
    snap = rsp_cnt;
    rst = 1'b1;
    #1;
    check_value("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_value("t6_htrans",    32'(bus.htrans),    32'd0);
    check_value("t6_hsel",      32'(bus.hsel),      32'd0);
    check_value("t6_haddr",     32'(bus.haddr),     32'd0);
    check_value("t6_hwdata",    32'(bus.hwdata),    32'd0);
    check_value("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tb_hready = 1'b1;
    repeat (5) tick();
    check_value("t6_no_rsp", 32'(rsp_cnt), 32'(snap));
    push(1'b0, 4'h2, 1'b1, 16'h0000);
    push(1'b0, 4'h4, 1'b1, 16'h0000);
    expect_rsp("t6_r2", 16'h1234, 1'b0);
    expect_rsp("t6_r4", 16'hAB3C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
